// File: rtl/cpu_pkg.sv
// Shared CPU definitions: 8-bit opcode constants, the fetch-unit state
// encoding and the two-word opcode check. Imported by the fetch unit,
// the instruction memory and the control unit so they agree on encodings.
package cpu_pkg;

   localparam logic [7:0] OP_LDAC   = 8'd1;
   localparam logic [7:0] OP_STAC   = 8'd2;
   localparam logic [7:0] OP_MVAC   = 8'd3;
   localparam logic [7:0] OP_MOVR   = 8'd4;
   localparam logic [7:0] OP_ADD    = 8'd5;
   localparam logic [7:0] OP_SUB    = 8'd6;
   localparam logic [7:0] OP_INAC   = 8'd7;
   localparam logic [7:0] OP_CLAC   = 8'd8;
   localparam logic [7:0] OP_AND    = 8'd9;
   localparam logic [7:0] OP_OR     = 8'd10;
   localparam logic [7:0] OP_XOR    = 8'd11;
   localparam logic [7:0] OP_NOT    = 8'd12;
   localparam logic [7:0] OP_LOADIM = 8'd33;
   localparam logic [7:0] OP_JUMPZ  = 8'd35;
   localparam logic [7:0] OP_JUMPNZ = 8'd39;
   localparam logic [7:0] OP_JUMP   = 8'd40;
   localparam logic [7:0] OP_ENDOP  = 8'd42;

   typedef enum logic [2:0] {
      S_FETCH    = 3'd0,
      S_OPC      = 3'd1,
      S_FETCH_OP = 3'd2,
      S_OPND     = 3'd3,
      S_VALID    = 3'd4,
      S_HALT     = 3'd5
   } fetch_state_t;

   // Opcodes that carry a 16-bit operand in the following memory word.
   function automatic logic is_two_word(input logic [7:0] opcode);
      return (opcode == OP_LOADIM) || (opcode == OP_JUMPZ) ||
             (opcode == OP_JUMPNZ) || (opcode == OP_JUMP);
   endfunction

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch unit. Reads one- or two-word instructions from a
// memory with one cycle of read latency, holds the decoded opcode/operand
// until the control unit acknowledges, follows unconditional jumps itself
// and accepts redirects (taken conditional branches) from the control unit.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   mem_addr        word address to instruction memory (always = pc)
//   mem_rd_data     memory word, valid one cycle after mem_addr
//   mem_write_en    tied 0, the fetch unit never writes
//   ir_valid        opcode/operand held and ready
//   ir_ack          control unit consumes the instruction
//   ir_opcode       opcode (low byte of the first word)
//   ir_operand      second word of a two-word instruction, else 0
//   pc              address of the next word to fetch
//   redirect_en     force a fetch from redirect_addr
//   redirect_addr   redirect target
//   halted          endop has been consumed
//
// state      | meaning
// S_FETCH    | address presented, waiting for memory latency
// S_OPC      | opcode word on mem_rd_data: latch opcode, pc+1
// S_FETCH_OP | operand address presented, waiting for memory latency
// S_OPND     | operand word on mem_rd_data: latch operand, pc+1
// S_VALID    | instruction held, waiting for ir_ack
// S_HALT     | endop consumed, terminal until reset
module instr_fetch
   import cpu_pkg::*;
#(
   parameter logic [15:0] RESET_PC = 16'd0
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [15:0] mem_addr,
   input  logic [15:0] mem_rd_data,
   output logic        mem_write_en,
   output logic        ir_valid,
   input  logic        ir_ack,
   output logic [7:0]  ir_opcode,
   output logic [15:0] ir_operand,
   output logic [15:0] pc,
   input  logic        redirect_en,
   input  logic [15:0] redirect_addr,
   output logic        halted
);

   fetch_state_t state_q, state_d;
   logic [15:0]  pc_d;
   logic [7:0]   opcode_d;
   logic [15:0]  operand_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_FETCH;
         pc         <= RESET_PC;
         ir_opcode  <= 8'd0;
         ir_operand <= 16'd0;
      end else begin
         state_q    <= state_d;
         pc         <= pc_d;
         ir_opcode  <= opcode_d;
         ir_operand <= operand_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      pc_d      = pc;
      opcode_d  = ir_opcode;
      operand_d = ir_operand;
      // Redirect outranks everything, including an ack on jump/endop;
      // whatever was partially fetched is simply dropped.
      if (redirect_en && (state_q != S_HALT)) begin
         pc_d    = redirect_addr;
         state_d = S_FETCH;
      end else begin
         case (state_q)
            S_FETCH: state_d = S_OPC;
            S_OPC: begin
               opcode_d = mem_rd_data[7:0];
               pc_d     = pc + 16'd1;
               if (is_two_word(mem_rd_data[7:0])) begin
                  state_d = S_FETCH_OP;
               end else begin
                  operand_d = 16'd0;
                  state_d   = S_VALID;
               end
            end
            S_FETCH_OP: state_d = S_OPND;
            S_OPND: begin
               operand_d = mem_rd_data;
               pc_d      = pc + 16'd1;
               state_d   = S_VALID;
            end
            S_VALID: begin
               if (ir_ack) begin
                  if (ir_opcode == OP_JUMP) begin
                     pc_d    = ir_operand;
                     state_d = S_FETCH;
                  end else if (ir_opcode == OP_ENDOP) begin
                     state_d = S_HALT;
                  end else begin
                     state_d = S_FETCH;
                  end
               end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
         endcase
      end
   end

   assign mem_addr     = pc;
   assign mem_write_en = 1'b0;
   assign ir_valid     = (state_q == S_VALID);
   assign halted       = (state_q == S_HALT);

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] mem_addr;
   logic [15:0] mem_rd_data;
   logic        mem_write_en;
   logic        ir_valid;
   logic        ir_ack;
   logic [7:0]  ir_opcode;
   logic [15:0] ir_operand;
   logic [15:0] pc;
   logic        redirect_en;
   logic [15:0] redirect_addr;
   logic        halted;

   logic [15:0] mem [0:65535];

   int n_tests = 0;
   int n_fail  = 0;

   instr_fetch #(.RESET_PC(16'd0)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .mem_addr      (mem_addr),
      .mem_rd_data   (mem_rd_data),
      .mem_write_en  (mem_write_en),
      .ir_valid      (ir_valid),
      .ir_ack        (ir_ack),
      .ir_opcode     (ir_opcode),
      .ir_operand    (ir_operand),
      .pc            (pc),
      .redirect_en   (redirect_en),
      .redirect_addr (redirect_addr),
      .halted        (halted)
   );

   always #5 clk = ~clk;

   // Synchronous-read instruction memory: data one cycle after the address.
   always @(posedge clk) mem_rd_data <= mem[mem_addr];

   typedef struct {
      logic [15:0] start;
      logic [15:0] w0;
      logic [15:0] w1;
      logic [7:0]  op;
      logic [15:0] opnd;
      logic [15:0] pc_after;
      int          lat;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic wait_valid(output int cyc);
      cyc = 0;
      while (!ir_valid && cyc < 20) begin
         tick();
         cyc++;
      end
   endtask

   initial begin
      int cyc;
      logic [7:0]  h_op;
      logic [15:0] h_opnd, h_pc;
      logic        h_ok;

      for (int i = 0; i < 65536; i++) mem[i] = 16'd0;
      rst_n = 1'b0; ir_ack = 1'b0; redirect_en = 1'b0; redirect_addr = 16'd0;

      vecs[0] = '{16'h0010, 16'h0005, 16'h0000, 8'd5,  16'h0000, 16'h0011, 2};
      vecs[1] = '{16'h0020, 16'h1221, 16'hBEEF, 8'd33, 16'hBEEF, 16'h0022, 4};
      vecs[2] = '{16'h0030, 16'h0023, 16'h1234, 8'd35, 16'h1234, 16'h0032, 4};
      vecs[3] = '{16'h0040, 16'hAB27, 16'h5A5A, 8'd39, 16'h5A5A, 16'h0042, 4};
      vecs[4] = '{16'h0050, 16'h0028, 16'h0077, 8'd40, 16'h0077, 16'h0052, 4};
      vecs[5] = '{16'h0060, 16'h002A, 16'h0000, 8'd42, 16'h0000, 16'h0061, 2};
      vecs[6] = '{16'hFFFF, 16'h0007, 16'h0000, 8'd7,  16'h0000, 16'h0000, 2};
      vecs[7] = '{16'hFFFF, 16'h0021, 16'hAAAA, 8'd33, 16'hAAAA, 16'h0001, 4};
      vecs[8] = '{16'h0070, 16'hFF22, 16'h0000, 8'd34, 16'h0000, 16'h0071, 2};
      vecs[9] = '{16'h0100, 16'h0129, 16'h0000, 8'd41, 16'h0000, 16'h0101, 2};

      // Reset values
      tick(); tick();
      check("rst_pc", pc, 16'd0);
      check("rst_valid", ir_valid, 1'b0);
      check("rst_opcode", ir_opcode, 8'd0);
      check("rst_operand", ir_operand, 16'd0);
      check("rst_halted", halted, 1'b0);
      check("mem_write_en", mem_write_en, 1'b0);

      // Single-instruction vectors, each started by a redirect after reset
      for (int v = 0; v < 10; v++) begin
         mem[vecs[v].start]         = vecs[v].w0;
         mem[vecs[v].start + 16'd1] = vecs[v].w1;
         do_reset();
         redirect_en = 1'b1; redirect_addr = vecs[v].start;
         tick();
         redirect_en = 1'b0;
         wait_valid(cyc);
         check($sformatf("v%0d_latency", v), cyc, vecs[v].lat);
         check($sformatf("v%0d_opcode", v), ir_opcode, vecs[v].op);
         check($sformatf("v%0d_operand", v), ir_operand, vecs[v].opnd);
         check($sformatf("v%0d_pc", v), pc, vecs[v].pc_after);
      end

      // loadim then single-word, acking each
      mem[0] = 16'd33; mem[1] = 16'd257; mem[2] = 16'd6;
      do_reset();
      wait_valid(cyc);
      check("a_latency1", cyc, 4);
      check("a_opcode1", ir_opcode, 8'd33);
      check("a_operand1", ir_operand, 16'd257);
      check("a_pc1", pc, 16'd2);
      ir_ack = 1'b1; tick(); ir_ack = 1'b0;
      wait_valid(cyc);
      check("a_latency2", cyc, 2);
      check("a_opcode2", ir_opcode, 8'd6);
      check("a_operand2", ir_operand, 16'd0);
      check("a_pc2", pc, 16'd3);

      // Hold without ack: everything stays put
      h_op = ir_opcode; h_opnd = ir_operand; h_pc = pc;
      for (int i = 0; i < 10; i++) begin
         tick();
         h_ok = ir_valid && (ir_opcode == h_op) && (ir_operand == h_opnd) &&
                (pc == h_pc) && (mem_addr == h_pc);
         check($sformatf("hold_stable_%0d", i), h_ok, 1'b1);
      end

      // jump followed from inside the fetch unit
      mem[0] = 16'd40; mem[1] = 16'd9; mem[9] = 16'd41;
      do_reset();
      wait_valid(cyc);
      check("j_opcode1", ir_opcode, 8'd40);
      check("j_operand1", ir_operand, 16'd9);
      ir_ack = 1'b1; tick(); ir_ack = 1'b0;
      check("j_pc_target", pc, 16'd9);
      wait_valid(cyc);
      check("j_opcode2", ir_opcode, 8'd41);
      check("j_pc2", pc, 16'd10);

      // Redirect while in S_OPND discards the operand fetch
      mem[0] = 16'd33; mem[1] = 16'd5; mem[129] = 16'h0003;
      do_reset();
      tick(); tick(); tick();
      check("r1_pc_in_opnd", pc, 16'd1);
      redirect_en = 1'b1; redirect_addr = 16'd129;
      tick();
      redirect_en = 1'b0;
      check("r1_valid_dropped", ir_valid, 1'b0);
      check("r1_pc", pc, 16'd129);
      wait_valid(cyc);
      check("r1_latency", cyc, 2);
      check("r1_opcode", ir_opcode, 8'd3);
      check("r1_pc_after", pc, 16'd130);

      // Redirect together with ack on a jump: redirect wins
      mem[0] = 16'd40; mem[1] = 16'd9; mem[129] = 16'h0004;
      do_reset();
      wait_valid(cyc);
      check("r2_opcode_jump", ir_opcode, 8'd40);
      ir_ack = 1'b1; redirect_en = 1'b1; redirect_addr = 16'd129;
      tick();
      ir_ack = 1'b0; redirect_en = 1'b0;
      check("r2_valid_dropped", ir_valid, 1'b0);
      check("r2_pc", pc, 16'd129);
      wait_valid(cyc);
      check("r2_opcode", ir_opcode, 8'd4);
      check("r2_pc_after", pc, 16'd130);

      // endop halts; redirect ignored; reset recovers
      mem[0] = 16'd42;
      do_reset();
      wait_valid(cyc);
      check("h_opcode", ir_opcode, 8'd42);
      ir_ack = 1'b1; tick(); ir_ack = 1'b0;
      check("h_halted", halted, 1'b1);
      check("h_valid", ir_valid, 1'b0);
      redirect_en = 1'b1; redirect_addr = 16'd129;
      tick(); tick(); tick();
      redirect_en = 1'b0;
      check("h_halted_redirect", halted, 1'b1);
      check("h_valid_redirect", ir_valid, 1'b0);
      check("h_pc_redirect", pc, 16'd1);
      rst_n = 1'b0;
      #1;
      check("h_async_pc", pc, 16'd0);
      check("h_async_halted", halted, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      check("h_rel_pc", pc, 16'd0);
      check("h_rel_halted", halted, 1'b0);
      wait_valid(cyc);
      check("h_refetch_latency", cyc, 2);
      check("h_refetch_opcode", ir_opcode, 8'd42);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'd0, meaning the PC value loaded on reset.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset. One clock; reset is asynchronous and active-low.
REQ-004 SHALL have port mem_addr  output  16  word address to the instruction memory.
REQ-005 SHALL have port mem_rd_data  input  16  memory read word, valid one cycle after mem_addr is presented.
REQ-006 SHALL have port mem_write_en  output  1  constant 0; the fetch unit never writes.
REQ-007 SHALL have port ir_valid  output  1  the decoded instruction is held and ready.
REQ-008 SHALL have port ir_ack  input  1  the control unit consumes the instruction.
REQ-009 SHALL have port ir_opcode  output  8  opcode, taken from mem_rd_data[7:0].
REQ-010 SHALL have port ir_operand  output  16  second word of a two-word instruction, else 0.
REQ-011 SHALL have port pc  output  16  address of the next word to fetch.
REQ-012 SHALL have port redirect_en  input  1  control unit forces a fetch from a new address (taken jumpz/jumpnz).
REQ-013 SHALL have port redirect_addr  input  16  target address for the redirect.
REQ-014 SHALL have port halted  output  1  endop has been consumed.

Function
REQ-015 SHALL implement the states S_FETCH, S_OPC, S_FETCH_OP, S_OPND, S_VALID and S_HALT.
REQ-016 SHALL drive mem_addr = pc combinationally in every state.
- S_FETCH: SHALL wait one cycle for memory latency, then go to S_OPC.
REQ-017 In S_OPC the block SHALL latch ir_opcode = mem_rd_data[7:0] and increment pc.
- If the opcode is a two-word opcode it SHALL go to S_FETCH_OP.
- Otherwise it SHALL clear ir_operand and go to S_VALID.
REQ-018 The two-word opcodes SHALL be loadim = 33, jumpz = 35, jumpnz = 39 and jump = 40.
REQ-019 S_FETCH_OP SHALL take one cycle and then go to S_OPND.
- S_OPND SHALL latch ir_operand = mem_rd_data, increment pc, and go to S_VALID.
REQ-020 In S_VALID the block SHALL assert ir_valid and hold ir_opcode and ir_operand stable until ir_ack is sampled high.
REQ-021 When ir_ack is sampled high in S_VALID, the block SHALL act by opcode:
- opcode = jump (40): pc <= ir_operand, then S_FETCH.
- opcode = endop (42): go to S_HALT.
- any other opcode: go to S_FETCH.
REQ-022 ir_ack outside S_VALID SHALL be ignored.
REQ-023 Latency: a single-word instruction SHALL present ir_valid 2 cycles after entering S_FETCH; a two-word instruction SHALL take 4 cycles.
REQ-024 redirect_en SHALL have priority over all other transitions in every state except S_HALT.
- It SHALL set pc <= redirect_addr, drop ir_valid the next cycle, and go to S_FETCH.
- Any partial fetch in progress SHALL be discarded.
REQ-025 If redirect_en and ir_ack are high in the same S_VALID cycle, the redirect SHALL win, including over jump and endop.
REQ-026 pc SHALL be 16 bits, increment modulo 2^16 (16'hFFFF + 1 = 16'h0000), and raise no error on wrap.
REQ-027 S_HALT SHALL be terminal until reset.
- halted SHALL be 1 and ir_valid 0.
- redirect_en SHALL be ignored.

Reset
REQ-028 While rst_n = 0, the block SHALL immediately and asynchronously hold these values:
- state = S_FETCH, pc = RESET_PC;
- ir_valid = 0, ir_opcode = 0, ir_operand = 0, halted = 0.
REQ-029 Reset asserted mid-instruction SHALL abandon the instruction; the first fetch after release SHALL be from RESET_PC.

Structure
REQ-030 Opcode constants (ldac through endop, 8-bit) and the state encoding SHALL live in the shared package cpu_pkg, so that this block, instr_memory and the control unit agree.
REQ-031 The block SHALL be a single module with no sub-module; the two-word-opcode check SHALL be a package function is_two_word(opcode).

Verification
REQ-032 Memory {0: 33, 1: 257, 2: 6}; ack each ir_valid -> first ir_valid with opcode 33 and operand 257 at 4 cycles (pc = 2), then opcode 6 and operand 0 (pc = 3).
REQ-033 Memory {0: 40, 1: 9, 9: 41}; ack each ir_valid -> opcode 40 and operand 9, then the next fetch is from address 9, giving opcode 41.
REQ-034 Hold ir_ack = 0 for 10 cycles in S_VALID -> ir_valid, ir_opcode, ir_operand and pc stay stable and no memory address change occurs.
REQ-035 redirect_en = 1 with redirect_addr = 129 while in S_OPND, and separately the same redirect together with ir_ack on a jump -> the next ir_valid carries the opcode from address 129 both times.
REQ-036 Memory {0: 42}; ack -> halted = 1 and ir_valid = 0 thereafter, with redirect ignored; assert rst_n low for 1 cycle mid-halt -> pc = 0 and halted = 0.
REQ-037 Start with pc = 16'hFFFF via redirect on a single-word opcode -> pc wraps to 16'h0000 after S_OPC.
